// File: rtl/relcache_pkg.sv
// Shared types and constants for the relational cache datapath.
// Contents:
//   DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH  widths shared with the packer stage
//   LINE_BYTES                              bytes per packed line
//   writer_state_t                          packed_line_writer FSM states
package relcache_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 512;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
  localparam int unsigned LINE_BYTES         = DEFAULT_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } writer_state_t;

endpackage

// File: rtl/line_fifo.sv
// Two-entry line buffer between the packer handshake and the line store write port.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset (flushes contents)
//   push_i         write push_data_i into the tail (ignored when full)
//   push_data_i    line to store
//   pop_i          drop the head entry (ignored when empty)
//   head_o         current head entry (zero after reset)
//   count_o        number of valid entries, 0..2
module line_fifo #(
  parameter int unsigned DATA_WIDTH = 512
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  push_ok;
  logic                  pop_ok;

  assign push_ok = push_i & (count_q != 2'd2);
  assign pop_ok  = pop_i & (count_q != 2'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 2'd1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/packed_line_writer.sv
// Accepts full packed lines from the packer (activate/consumed handshake), buffers them
// in a 2-entry FIFO and writes them to consecutive line indices of the cache line store.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               job start, honoured only when idle
//   base_line           first destination line index (latched on start)
//   line_count          lines in the job (latched on start)
//   in_valid, in_data   packer activate and line
//   consumed            one-cycle accept pulse to the packer (combinational)
//   wr_valid, wr_ready  line store write handshake
//   wr_addr, wr_data    write destination and data
//   busy                job in progress
//   done                one-cycle completion pulse
//   lines_written       lines committed in the current or last job
module packed_line_writer
  import relcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_line,
  input  logic [COUNT_WIDTH-1:0] line_count,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   consumed,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] lines_written
);

  localparam logic [COUNT_WIDTH-1:0] CountOne = 1;

  writer_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] accepted_q;
  logic [COUNT_WIDTH-1:0] written_q;
  logic                   consumed_q;
  logic [1:0]             fifo_count;
  logic [DATA_WIDTH-1:0]  fifo_head;
  logic                   wr_fire;
  logic                   job_start;

  line_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (consumed),
    .push_data_i(in_data),
    .pop_i      (wr_fire),
    .head_o     (fifo_head),
    .count_o    (fifo_count)
  );

  assign job_start = (state_q == StIdle) & start;
  assign busy      = (state_q == StRun) | (state_q == StDrain);
  assign done      = (state_q == StDone);

  // consumed_q enforces the idle cycle the packer needs to lower activate.
  assign consumed = (state_q == StRun) & in_valid & (fifo_count < 2'd2) & ~consumed_q &
                    (accepted_q < count_q);

  assign wr_valid      = busy & (fifo_count != 2'd0);
  assign wr_fire       = wr_valid & wr_ready;
  assign wr_data       = fifo_head;
  assign wr_addr       = base_q + ADDR_WIDTH'(written_q);
  assign lines_written = written_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (line_count == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (accepted_q == count_q) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_count == 2'd0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      base_q     <= '0;
      count_q    <= '0;
      accepted_q <= '0;
      written_q  <= '0;
      consumed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      consumed_q <= consumed;
      if (job_start) begin
        base_q     <= base_line;
        count_q    <= line_count;
        accepted_q <= '0;
        written_q  <= '0;
      end else begin
        if (consumed) begin
          accepted_q <= accepted_q + CountOne;
        end
        if (wr_fire) begin
          written_q <= written_q + CountOne;
        end
      end
    end
  end

endmodule

// File: tb/tb_packed_line_writer.sv
module tb_packed_line_writer;

  logic         clock;
  logic         reset;
  logic         start;
  logic [31:0]  base_line;
  logic [31:0]  line_count;
  logic         in_valid;
  logic [511:0] in_data;
  logic         consumed;
  logic         wr_valid;
  logic         wr_ready;
  logic [31:0]  wr_addr;
  logic [511:0] wr_data;
  logic         busy;
  logic         done;
  logic [31:0]  lines_written;

  packed_line_writer #(
    .DATA_WIDTH (512),
    .ADDR_WIDTH (32),
    .COUNT_WIDTH(32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .base_line    (base_line),
    .line_count   (line_count),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .consumed     (consumed),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .lines_written(lines_written)
  );

  typedef struct {
    logic [31:0]  a;
    logic [511:0] d;
  } wr_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Packer model state.
  int pk_job = 0;
  int pk_idx = 0;
  int pk_n = 0;
  bit cons_seen = 0;

  // Scoreboard / observation state.
  wr_t         exp_q[$];
  int          cons_log[$];
  logic [31:0] wlog[$];
  int          cons_cnt = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          first_hs_cyc = -1;
  bit          busy_seen = 0;
  bit          start_real = 0;
  logic [31:0] mw = 0;
  bit          stall_prev = 0;
  bit          cons_prev = 0;
  logic [31:0]  prev_addr;
  logic [511:0] prev_data;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mkline(input int job, input int k);
    logic [511:0] l;
    logic [31:0]  w;
    w = 32'hC0DE0000 ^ (32'(job) << 8) ^ 32'(k);
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = w + 32'(i) * 32'h01010101;
    return l;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Packer: presents its next line whenever it has one, advancing after each consume.
  initial begin
    in_valid = 0;
    in_data  = '0;
    forever begin
      @(posedge clock);
      #2;
      if (cons_seen) begin
        pk_idx++;
        cons_seen = 0;
      end
      if (pk_idx < pk_n) begin
        in_valid = 1;
        in_data  = mkline(pk_job, pk_idx);
      end else begin
        in_valid = 0;
        in_data  = '0;
      end
    end
  end

  // Single compare process: every cycle, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        mw         = 0;
        stall_prev = 0;
        cons_prev  = 0;
      end else begin
        chk("lines_written", lines_written, mw);
        chk("consume_spacing", consumed & cons_prev, 0);
        chk("consume_needs_valid", consumed & ~in_valid, 0);
        chk("consume_needs_busy", consumed & ~busy, 0);
        if (stall_prev) begin
          chk("hold_valid", wr_valid, 1);
          chk("hold_addr", wr_addr, prev_addr);
          chk("hold_data", wr_data, prev_data);
        end
        if (consumed) begin
          cons_cnt++;
          cons_log.push_back(cyc);
          cons_seen = 1;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (busy) busy_seen = 1;
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", wr_addr, e.a);
            chk("wr_data", wr_data, e.d);
          end
          wlog.push_back(wr_addr);
          hs_cnt++;
          if (first_hs_cyc < 0) first_hs_cyc = cyc;
          mw = mw + 1;
        end
        stall_prev = wr_valid & ~wr_ready;
        prev_addr  = wr_addr;
        prev_data  = wr_data;
        cons_prev  = consumed;
        if (start && start_real) mw = 0;
      end
    end
  end

  // Issues start in the current cycle; returns one cycle later. Returns the start cycle.
  task automatic start_job(input logic [31:0] b, input logic [31:0] n, input int job,
                           output int s);
    for (int k = 0; k < int'(n); k++) begin
      wr_t e;
      e.a = b + 32'(k);
      e.d = mkline(job, k);
      exp_q.push_back(e);
    end
    cons_log.delete();
    wlog.delete();
    cons_cnt     = 0;
    hs_cnt       = 0;
    first_hs_cyc = -1;
    busy_seen    = 0;
    pk_job       = job;
    pk_idx       = 0;
    cons_seen    = 0;
    pk_n         = int'(n) + 1;  // one spare line exposes over-consumption
    base_line    = b;
    line_count   = n;
    start        = 1;
    start_real   = 1;
    s            = cyc;
    tick();
    start      = 0;
    start_real = 0;
  endtask

  task automatic wait_done(input int bound);
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      if (done_cnt > d0) begin
        seen = 1;
        break;
      end
      tick();
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_consumed"}, consumed, 0);
    chk({tag, "_wr_valid"}, wr_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_lines_written"}, lines_written, 0);
  endtask

  initial begin
    int s;
    int d0;
    reset      = 1;
    start      = 0;
    base_line  = 0;
    line_count = 0;
    wr_ready   = 0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 0;
    tick();

    // Job 1: three lines, store always ready.
    wr_ready = 1;
    d0 = done_cnt;
    start_job(32'h100, 3, 1, s);
    wait_done(40);
    repeat (3) tick();
    chk("j1_consumes", cons_cnt, 3);
    if (cons_log.size() == 3) begin
      chk("j1_cons0_cycle", cons_log[0], s + 1);
      chk("j1_cons1_cycle", cons_log[1], s + 3);
      chk("j1_cons2_cycle", cons_log[2], s + 5);
    end
    if (wlog.size() == 3) begin
      chk("j1_addr0", wlog[0], 32'h100);
      chk("j1_addr1", wlog[1], 32'h101);
      chk("j1_addr2", wlog[2], 32'h102);
    end
    chk("j1_writes", hs_cnt, 3);
    chk("j1_done_cycle", done_cyc, s + 8);
    chk("j1_done_once", done_cnt - d0, 1);
    chk("j1_lines_written", lines_written, 3);
    chk("j1_sb_empty", exp_q.size(), 0);

    // Job 2: zero lines.
    d0 = done_cnt;
    start_job(32'h55, 0, 2, s);
    wait_done(10);
    repeat (3) tick();
    chk("j2_consumes", cons_cnt, 0);
    chk("j2_busy_never", busy_seen, 0);
    chk("j2_done_latency", (done_cyc == s + 1) || (done_cyc == s + 2), 1);
    chk("j2_done_once", done_cnt - d0, 1);
    chk("j2_lines_written", lines_written, 0);

    // Job 3: store stalled for 10 cycles, four lines.
    wr_ready = 0;
    start_job(32'h200, 4, 3, s);
    repeat (9) tick();
    chk("j3_stall_consumes", cons_cnt, 2);
    chk("j3_stall_writes", hs_cnt, 0);
    wr_ready = 1;
    wait_done(60);
    repeat (2) tick();
    chk("j3_consumes", cons_cnt, 4);
    chk("j3_writes", hs_cnt, 4);
    if (cons_log.size() == 4) chk("j3_third_after_write", cons_log[2] > first_hs_cyc, 1);
    chk("j3_lines_written", lines_written, 4);
    chk("j3_sb_empty", exp_q.size(), 0);

    // Job 4: address wrap.
    start_job(32'hFFFF_FFFF, 2, 4, s);
    wait_done(40);
    repeat (2) tick();
    if (wlog.size() == 2) begin
      chk("j4_addr0", wlog[0], 32'hFFFF_FFFF);
      chk("j4_addr1", wlog[1], 32'h0000_0000);
    end
    chk("j4_writes", hs_cnt, 2);
    chk("j4_sb_empty", exp_q.size(), 0);

    // Job 5: reset in DRAIN with one line still buffered.
    wr_ready = 0;
    start_job(32'h300, 2, 5, s);
    repeat (4) tick();
    chk("j5_busy_before", busy, 1);
    wr_ready = 1;
    tick();
    wr_ready = 0;
    chk("j5_one_buffered", wr_valid, 1);
    chk("j5_first_write", hs_cnt, 1);
    reset = 1;
    pk_n  = 0;
    tick();
    reset = 0;
    check_idle_outputs("j5_after_reset");
    repeat (2) tick();
    wr_ready = 1;
    start_job(32'h400, 2, 6, s);
    wait_done(40);
    repeat (2) tick();
    chk("j5_clean_writes", hs_cnt, 2);
    chk("j5_clean_lines_written", lines_written, 2);
    chk("j5_sb_empty", exp_q.size(), 0);

    // Job 6: start during RUN is ignored.
    start_job(32'h500, 3, 7, s);
    tick();
    base_line  = 32'h999;
    line_count = 7;
    start      = 1;
    tick();
    start = 0;
    wait_done(40);
    repeat (2) tick();
    chk("j6_consumes", cons_cnt, 3);
    if (wlog.size() == 3) chk("j6_addr2", wlog[2], 32'h502);
    chk("j6_lines_written", lines_written, 3);
    chk("j6_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
